// File: rtl/galaga_pkg.sv
// Shared encodings and sprite geometry for the galaga title/game-over overlay path.
package galaga_pkg;

  typedef enum logic [1:0] {
    GS_TITLE    = 2'b00,
    GS_PLAY     = 2'b01,
    GS_GAMEOVER = 2'b10
  } game_state_t;

  typedef enum logic [1:0] {
    OVL_NONE  = 2'd0,
    OVL_LOGO  = 2'd1,
    OVL_PRESS = 2'd2,
    OVL_GO    = 2'd3
  } ovl_color_t;

  typedef enum logic [2:0] {
    ANIM_IDLE,
    ANIM_TITLE,
    ANIM_GO_SCROLL,
    ANIM_GO_HOLD,
    ANIM_GO_DONE
  } anim_state_t;

  // Sprite ROM dimensions and log2 of the on-screen scale factor.
  localparam int unsigned LOGO_W   = 96;
  localparam int unsigned LOGO_H   = 16;
  localparam int unsigned LOGO_SH  = 1;
  localparam int unsigned PRESS_W  = 55;
  localparam int unsigned PRESS_H  = 5;
  localparam int unsigned PRESS_SH = 2;
  localparam int unsigned GO_W     = 128;
  localparam int unsigned GO_H     = 16;
  localparam int unsigned GO_SH    = 2;

  function automatic logic [9:0] box_extent(input int unsigned n, input int unsigned sh);
    return 10'(n << sh);
  endfunction

endpackage

// File: rtl/overlay_anim_ctrl.sv
// Overlay animation sequencer: title blink, game-over banner scroll/hold and go_done pulse.
module overlay_anim_ctrl
  import galaga_pkg::*;
#(
  parameter logic [9:0]  GO_Y_FINAL   = 10'd208,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES  = 180
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [1:0] game_state,
  output logic [9:0] go_y,
  output logic       logo_en,
  output logic       press_en,
  output logic       go_en,
  output logic       go_done
);

  localparam int unsigned BW = $clog2(BLINK_FRAMES);
  localparam int unsigned HW = $clog2(HOLD_FRAMES);

  anim_state_t   state, state_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [9:0]    go_y_n, go_y_step;
  logic          blink_vis, blink_vis_n;
  logic          go_done_n;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ANIM_IDLE;
      blink_cnt <= '0;
      hold_cnt  <= '0;
      go_y      <= '0;
      blink_vis <= 1'b1;
      go_done   <= 1'b0;
    end else begin
      state     <= state_n;
      blink_cnt <= blink_cnt_n;
      hold_cnt  <= hold_cnt_n;
      go_y      <= go_y_n;
      blink_vis <= blink_vis_n;
      go_done   <= go_done_n;
    end
  end

  // A game_state change is tested before frame_tick, so a coincident tick is dropped.
  always_comb begin
    state_n     = state;
    blink_cnt_n = blink_cnt;
    hold_cnt_n  = hold_cnt;
    go_y_n      = go_y;
    blink_vis_n = blink_vis;
    go_done_n   = 1'b0;
    go_y_step   = go_y + 10'd2;
    if (game_state == GS_PLAY) begin
      state_n     = ANIM_IDLE;
      blink_cnt_n = '0;
      hold_cnt_n  = '0;
      go_y_n      = '0;
      blink_vis_n = 1'b1;
    end else begin
      case (state)
        ANIM_IDLE: begin
          blink_cnt_n = '0;
          hold_cnt_n  = '0;
          go_y_n      = '0;
          blink_vis_n = 1'b1;
          if (game_state == GS_TITLE)         state_n = ANIM_TITLE;
          else if (game_state == GS_GAMEOVER) state_n = ANIM_GO_SCROLL;
        end
        ANIM_TITLE: begin
          if (game_state != GS_TITLE) begin
            state_n = ANIM_IDLE;
          end else if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
              blink_cnt_n = '0;
              blink_vis_n = !blink_vis;
            end else begin
              blink_cnt_n = blink_cnt + 1'b1;
            end
          end
        end
        ANIM_GO_SCROLL: begin
          if (game_state != GS_GAMEOVER) begin
            state_n = ANIM_IDLE;
          end else if (frame_tick) begin
            if (go_y_step >= GO_Y_FINAL) begin
              go_y_n     = GO_Y_FINAL;
              hold_cnt_n = '0;
              state_n    = ANIM_GO_HOLD;
            end else begin
              go_y_n = go_y_step;
            end
          end
        end
        ANIM_GO_HOLD: begin
          if (game_state != GS_GAMEOVER) begin
            state_n = ANIM_IDLE;
          end else if (frame_tick) begin
            if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
              go_done_n = 1'b1;
              state_n   = ANIM_GO_DONE;
            end else begin
              hold_cnt_n = hold_cnt + 1'b1;
            end
          end
        end
        ANIM_GO_DONE: begin
          if (game_state != GS_GAMEOVER) state_n = ANIM_IDLE;
        end
        default: state_n = ANIM_IDLE;
      endcase
    end
  end

  always_comb begin
    logo_en  = (state == ANIM_TITLE);
    press_en = (state == ANIM_TITLE) && blink_vis;
    go_en    = (state == ANIM_GO_SCROLL) || (state == ANIM_GO_HOLD) || (state == ANIM_GO_DONE);
  end

endmodule

// File: rtl/title_overlay_renderer.sv
// Overlay renderer: addresses the three logo ROMs from the scan position and registers the lit pixel.
module title_overlay_renderer
  import galaga_pkg::*;
#(
  parameter logic [9:0]  LOGO_X0      = 10'd112,
  parameter logic [9:0]  LOGO_Y0      = 10'd96,
  parameter logic [9:0]  PRESS_X0     = 10'd210,
  parameter logic [9:0]  PRESS_Y0     = 10'd300,
  parameter logic [9:0]  GO_X0        = 10'd64,
  parameter logic [9:0]  GO_Y_FINAL   = 10'd208,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES  = 180
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_tick,
  input  logic [1:0]   game_state,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  output logic [3:0]   logo_addr,
  input  logic [95:0]  logo_data,
  output logic [3:0]   go_addr,
  input  logic [127:0] go_data,
  output logic [2:0]   press_addr,
  input  logic [54:0]  press_data,
  output logic         ovl_on,
  output logic [1:0]   ovl_color,
  output logic         go_done
);

  localparam logic [9:0] LOGO_BW  = box_extent(LOGO_W, LOGO_SH);
  localparam logic [9:0] LOGO_BH  = box_extent(LOGO_H, LOGO_SH);
  localparam logic [9:0] PRESS_BW = box_extent(PRESS_W, PRESS_SH);
  localparam logic [9:0] PRESS_BH = box_extent(PRESS_H, PRESS_SH);
  localparam logic [9:0] GO_BW    = box_extent(GO_W, GO_SH);
  localparam logic [9:0] GO_BH    = box_extent(GO_H, GO_SH);

  logic [9:0] go_y;
  logic       logo_en, press_en, go_en;

  overlay_anim_ctrl #(
    .GO_Y_FINAL   (GO_Y_FINAL),
    .BLINK_FRAMES (BLINK_FRAMES),
    .HOLD_FRAMES  (HOLD_FRAMES)
  ) u_anim (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .game_state (game_state),
    .go_y       (go_y),
    .logo_en    (logo_en),
    .press_en   (press_en),
    .go_en      (go_en),
    .go_done    (go_done)
  );

  logic       logo_in, press_in, go_in;
  logic [9:0] logo_dx, logo_dy, press_dx, press_dy, go_dx, go_dy;
  logic [6:0] logo_col, go_col;
  logic [5:0] press_col;
  logic       logo_bit, press_bit, go_bit;
  ovl_color_t pix_color;

  // Offsets are forced to zero outside a box, so no wrapped subtraction reaches a ROM.
  always_comb begin
    logo_in  = (DrawX >= LOGO_X0) && (DrawX < LOGO_X0 + LOGO_BW) &&
               (DrawY >= LOGO_Y0) && (DrawY < LOGO_Y0 + LOGO_BH);
    press_in = (DrawX >= PRESS_X0) && (DrawX < PRESS_X0 + PRESS_BW) &&
               (DrawY >= PRESS_Y0) && (DrawY < PRESS_Y0 + PRESS_BH);
    go_in    = go_en && (DrawX >= GO_X0) && (DrawX < GO_X0 + GO_BW) &&
               (DrawY >= go_y) && (DrawY < go_y + GO_BH);

    logo_dx  = logo_in  ? DrawX - LOGO_X0  : '0;
    logo_dy  = logo_in  ? DrawY - LOGO_Y0  : '0;
    press_dx = press_in ? DrawX - PRESS_X0 : '0;
    press_dy = press_in ? DrawY - PRESS_Y0 : '0;
    go_dx    = go_in    ? DrawX - GO_X0    : '0;
    go_dy    = go_in    ? DrawY - go_y     : '0;

    logo_col   = 7'(logo_dx >> LOGO_SH);
    press_col  = 6'(press_dx >> PRESS_SH);
    go_col     = 7'(go_dx >> GO_SH);
    logo_addr  = 4'(logo_dy >> LOGO_SH);
    press_addr = 3'(press_dy >> PRESS_SH);
    go_addr    = 4'(go_dy >> GO_SH);

    logo_bit  = logo_data[7'(LOGO_W - 1) - logo_col];
    press_bit = press_data[6'(PRESS_W - 1) - press_col];
    go_bit    = go_data[7'(GO_W - 1) - go_col];
  end

  always_comb begin
    pix_color = OVL_NONE;
    if (game_state != GS_PLAY) begin
      if (go_in && go_bit)                        pix_color = OVL_GO;
      else if (logo_en && logo_in && logo_bit)    pix_color = OVL_LOGO;
      else if (press_en && press_in && press_bit) pix_color = OVL_PRESS;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovl_on    <= 1'b0;
      ovl_color <= '0;
    end else begin
      ovl_on    <= (pix_color != OVL_NONE);
      ovl_color <= pix_color;
    end
  end

endmodule
